// File: rtl/buzzer_front_end.sv
// Quiz buzzer input stage: synchronises and debounces player buttons, flags early presses
// as fouls, locks the first legal press of an armed round and runs the answer countdown.
module buzzer_front_end #(
   parameter int N_PLAYERS       = 4,
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ANSWER_SECS     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_PLAYERS-1:0] btn_raw,
   input  logic [N_PLAYERS-1:0] player_en,
   input  logic                 arm,
   input  logic                 clear,
   output logic [N_PLAYERS-1:0] answer,
   output logic                 answer_valid,
   output logic                 locked,
   output logic [N_PLAYERS-1:0] foul,
   output logic [3:0]           time_left,
   output logic                 timeout
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
   localparam logic [3:0]    SECS     = 4'(ANSWER_SECS);

   typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;

   state_t state, state_next;

   logic [N_PLAYERS-1:0]         sync1, sync2, db, db_d;
   logic [N_PLAYERS-1:0][DW-1:0] db_cnt;
   logic [TW-1:0]                tick;
   logic [N_PLAYERS-1:0]         rise, press, winner;
   logic                         tick_wrap;

   // A bit's debounced value follows the synced input only after it has disagreed
   // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_d   <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < N_PLAYERS; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign rise      = db & ~db_d & player_en;
   assign press     = rise & ~foul;
   assign winner    = press & (~press + N_PLAYERS'(1));
   assign tick_wrap = (tick == TICK_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (arm) state_next = ARMED;
         ARMED:   if (|press) state_next = LOCKED;
         LOCKED:  if (tick_wrap && time_left == 4'd1) state_next = TIMEOUT;
         TIMEOUT: state_next = TIMEOUT;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // Round datapath; clear outranks arm and press in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         answer       <= '0;
         answer_valid <= 1'b0;
         foul         <= '0;
         time_left    <= '0;
         tick         <= '0;
      end else begin
         answer_valid <= 1'b0;
         case (state)
            IDLE: foul <= foul | rise;
            ARMED: begin
               if (|press) begin
                  answer       <= winner;
                  answer_valid <= 1'b1;
                  time_left    <= SECS;
                  tick         <= '0;
               end
            end
            LOCKED: begin
               if (tick_wrap) begin
                  tick      <= '0;
                  time_left <= time_left - 4'd1;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign locked  = (state == LOCKED) || (state == TIMEOUT);
   assign timeout = (state == TIMEOUT);

endmodule
